byte_serial_add_seq: RTL
========================

// Module: byte_serial_add_seq
// PURPOSE
//  Sequences the shared 8-bit byte adder to add or subtract two NBYTES-wide operands,
//  one byte per beat, LSB first, with an internal carry register chaining the bytes.
//  Sits between the pin-level byte streams (ui_in/uio_in side) and uo_out.
//  Valid/ready on input and output; one result byte per accepted operand pair.
// PARAMETERS
//  NBYTES  4  operand width in bytes (2..16); beat counter is clog2(NBYTES) bits
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst_n      in   1  synchronous active-low reset
//  ena        in   1  clock enable; 0 freezes all state, forces in_ready=0
//  start      in   1  begin an operation (honoured in IDLE only)
//  sub        in   1  sampled with start: 0=A+B, 1=A-B
//  in_valid   in   1  a_byte/b_byte hold a valid operand pair
//  in_ready   out  1  pair accepted on in_valid&in_ready&ena
//  a_byte     in   8  operand A byte, LSB first
//  b_byte     in   8  operand B byte, LSB first
//  sum_byte   out  8  result byte (registered)
//  sum_valid  out  1  sum_byte valid
//  sum_ready  in   1  consumer accepts sum_byte on sum_valid&sum_ready
//  cout       out  1  final carry (sub: 1 = no borrow); valid when done pulses, held till next start
//  busy       out  1  state != IDLE
//  done       out  1  one-cycle pulse, operation complete
// BEHAVIOUR
//  Reset (rst_n=0 at edge, any state): state=IDLE, count=0, carry=0, sum_byte=0,
//   sum_valid=0, cout=0, done=0, sub_r=0. Mid-operation reset discards partial result.
//  FSM: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
//  IDLE: start=1 -> RUN; count=0; sub_r=sub; carry=sub; sum_valid unchanged.
//   start outside IDLE is ignored. in_ready=0 in IDLE.
//  RUN: in_ready = ena & (~sum_valid | sum_ready) (1-deep output register, full
//   throughput, no bubble). On accept: {c,s} = a + (sub_r ? ~b : b) + carry (9-bit);
//   sum_byte<=s; carry<=c; sum_valid<=1; count++. Accept with count==NBYTES-1:
//   cout<=c, -> FLUSH. in_valid without in_ready: operands must be held stable.
//  sum_valid clears on sum_ready when no new byte is loaded that cycle;
//   simultaneous drain+load keeps sum_valid=1 with new byte.
//  FLUSH: in_ready=0; when sum_valid=0 or (sum_valid&sum_ready) -> DONE.
//  DONE: done=1 for exactly this cycle, -> IDLE. A start in DONE is ignored.
//  Latency: result byte k valid 1 cycle after its operand pair accepted; done
//   asserts 1 cycle after last result byte consumed.
//  Carry wraps modulo 2^(8*NBYTES); overflow reported only via cout.
//  ena=0: no state/output register changes; sum_valid/sum_byte hold; done
//   stretches while ena=0 in DONE.
// TESTING (NBYTES=4)
//  1 add 0x12345678+0x11111111, no stall -> bytes 89,67,45,23 on 4 consecutive
//    cycles, cout=0, done 1 cycle after last byte taken.
//  2 add 0xFFFFFFFF+0x00000001 -> 00,00,00,00, cout=1 (carry ripples all bytes).
//  3 sub 0x00000001-0x00000002 -> FF,FF,FF,FF, cout=0; sub 5-3 -> 02,00,00,00, cout=1.
//  4 sum_ready=0 for 3 cycles after byte 1 -> in_ready=0, sum_byte held at byte 1,
//    no byte lost or duplicated; result as in case 1.
//  5 rst_n=0 after 2 bytes accepted -> next cycle busy=0, sum_valid=0, cout=0;
//    fresh add 0x01+0x01 yields 02,00,00,00, cout=0 (no stale carry).
//  6 start pulsed in RUN and DONE, ena=0 for 2 cycles mid-RUN -> ignored/frozen,
//    result unchanged vs case 1.

Source files
------------

// File: rtl/byte_serial_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : byte_serial_add_seq
//  Purpose  : Byte-serial NBYTES-wide add/subtract, LSB first, with carry chain
//             and valid/ready handshakes on operand and result streams.
//  Revision : 1.0  initial release
// ============================================================================
module byte_serial_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       sub,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic [7:0] sum_byte,
    output logic       sum_valid,
    input  logic       sum_ready,
    output logic       cout,
    output logic       busy,
    output logic       done
);

    localparam int            CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic          carry_q;
    logic          sub_q;
    logic [7:0]    sum_q;
    logic          sum_valid_q;
    logic          cout_q;
    logic          done_q;

    logic          accept;
    logic          drain;
    logic [8:0]    add_res;

    // Output register is one deep: a new byte may load while the old one drains.
    assign in_ready = ena & (state_q == S_RUN) & (~sum_valid_q | sum_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = ena & sum_valid_q & sum_ready;
    assign add_res  = {1'b0, a_byte} + {1'b0, (sub_q ? ~b_byte : b_byte)} + {8'd0, carry_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            sum_q       <= 8'd0;
            sum_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (ena) begin
            done_q <= 1'b0;

            if (accept) begin
                sum_q       <= add_res[7:0];
                carry_q     <= add_res[8];
                sum_valid_q <= 1'b1;
            end else if (drain) begin
                sum_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        count_q <= '0;
                        sub_q   <= sub;
                        carry_q <= sub;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (count_q == LAST) begin
                            cout_q  <= add_res[8];
                            count_q <= '0;
                            state_q <= S_FLUSH;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (!sum_valid_q || sum_ready) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sum_byte  = sum_q;
    assign sum_valid = sum_valid_q;
    assign cout      = cout_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule
`default_nettype wire
